// File: rtl/sm_conv_pkg.sv
// Shared constants, lane type and id-width helper for the sign-magnitude conversion scheduler.
package sm_conv_pkg;

  localparam int SM_W = 9;

  typedef logic [SM_W-1:0] sm_lane_t;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sm_lane_conv.sv
// Combinational conversion of one 9-bit sign-magnitude lane to 9-bit two's complement.
// Optional macro SM_CONV_NEGZERO_FIX_EN maps negative zero (0x100) to 0x000.
module sm_lane_conv
  import sm_conv_pkg::*;
(
  input  logic [SM_W-1:0] i_lane,
  output logic [SM_W-1:0] o_lane
);

  logic [7:0] w_mag_neg;

  always_comb begin
    w_mag_neg = 8'(~i_lane[7:0] + 8'd1);
    o_lane    = i_lane[8] ? {1'b1, w_mag_neg} : i_lane;
`ifdef SM_CONV_NEGZERO_FIX_EN
    if (i_lane == 9'h100) begin
      o_lane = '0;
    end
`endif
  end

endmodule

// File: rtl/sm_conv_sched.sv
// Round-robin arbiter feeding a two-stage sign-magnitude to two's-complement pipeline.
// Optional macro SM_CONV_NEGZERO_FIX_EN (in sm_lane_conv) outputs negative zero as 0x000.
module sm_conv_sched
  import sm_conv_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  LANES   = 8,
  localparam int IdW     = id_width(NUM_REQ),
  localparam int DW      = LANES * SM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic [IdW-1:0]        out_id,
  input  logic                  out_ready,
  output logic [31:0]           beat_cnt,
  output logic                  busy
);

  logic           r_s1_valid;
  logic [DW-1:0]  r_s1_data;
  logic [IdW-1:0] r_s1_id;
  logic           r_out_valid;
  logic [DW-1:0]  r_out_data;
  logic [IdW-1:0] r_out_id;
  logic [IdW-1:0] r_rr_ptr;
  logic [31:0]    r_beat_cnt;

  logic           w_s2_adv;
  logic           w_s1_adv;
  logic           w_gnt_any;
  logic [IdW-1:0] w_gnt_id;
  logic           w_accept;
  logic [DW-1:0]  w_gnt_data;
  logic [DW-1:0]  w_conv;

  function automatic logic [IdW-1:0] rr_wrap(input logic [IdW-1:0] base, input int offs);
    return IdW'((int'(base) + offs) % NUM_REQ);
  endfunction

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  // First valid requester at or after the round-robin pointer wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_gnt_any && req_valid[rr_wrap(r_rr_ptr, i)]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = rr_wrap(r_rr_ptr, i);
      end
    end
  end

  // Reset gating keeps req_ready low for the whole time rst is held.
  assign w_accept   = w_gnt_any && w_s1_adv && !rst;
  assign req_ready  = w_accept ? (NUM_REQ'(1) << w_gnt_id) : '0;
  assign w_gnt_data = req_data[w_gnt_id*DW +: DW];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sm_lane_conv u_lane_conv (
      .i_lane (r_s1_data[l*SM_W +: SM_W]),
      .o_lane (w_conv[l*SM_W +: SM_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_id     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_conv;
          r_out_id   <= r_s1_id;
        end
      end
      if (w_s1_adv) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_data <= w_gnt_data;
          r_s1_id   <= w_gnt_id;
        end
      end
      if (w_accept) begin
        r_rr_ptr <= rr_wrap(w_gnt_id, 1);
      end
      if (r_out_valid && out_ready) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign beat_cnt  = r_beat_cnt;
  assign busy      = r_s1_valid | r_out_valid;

endmodule

// File: doc/sm_conv_sched.md
SM_CONV_SCHED -- requirements
Module: sm_conv_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the conversion pipeline (2..8).
REQ-002 Parameter LANES, default 8, number of 9-bit sign-magnitude lanes per beat.
REQ-003 Port clk  in  1  single clock; every flop is rising-edge triggered on clk.
REQ-004 Port rst  in  1  reset, asynchronous and active-high.
REQ-005 Port req_valid  in  NUM_REQ  per-requester beat valid.
REQ-006 Port req_data  in  NUM_REQ x LANES*9  per-requester packed sign-magnitude lanes; bit 8 of each lane is the sign.
REQ-007 Port req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 Port out_valid  out  1  converted beat valid.
REQ-009 Port out_data  out  LANES*9  packed two's-complement lanes, lane i at bits [9i+8:9i].
REQ-010 Port out_id  out  clog2(NUM_REQ)  index of the requester that owns the out_data beat.
REQ-011 Port out_ready  in  1  downstream accept.
REQ-012 Port beat_cnt  out  32  count of beats delivered (out_valid and out_ready).
REQ-013 Port busy  out  1  high while any pipeline stage holds a beat.

Function
REQ-014 The block SHALL run a two-stage pipeline: S1 registers the granted req_data and id; S2 registers the converted lanes and id.
REQ-015 Latency SHALL be 2 cycles, from the req_valid&req_ready edge to out_valid high, when not stalled.
REQ-016 Sustained throughput SHALL be one beat per cycle while out_ready stays high.
REQ-017 Stall rule: S2 advances when !out_valid or out_ready; S1 advances when S1 is empty or S2 advances; a stall holds all stage contents unchanged.
REQ-018 The arbiter SHALL be round-robin. Search starts at rr_ptr. The first requester with req_valid is granted.
REQ-019 req_ready[g] SHALL be high only for the granted g, and only in a cycle in which S1 can accept.
REQ-020 rr_ptr SHALL update to (g+1) mod NUM_REQ after an accepted transfer and SHALL hold otherwise.
REQ-021 A requester SHALL hold req_valid and req_data stable until accepted; the block does not check this.
REQ-022 Lane conversion: sign=0 passes the lane unchanged; sign=1 outputs {1, (~mag+1) mod 256}.
REQ-023 Example lane conversions: 0x1FF becomes 0x101 (-255); 0x180 becomes 0x180 (-128).
REQ-024 Example lane conversion: 0x100 (negative zero) becomes 0x100 (-256) when SM_CONV_NEGZERO_FIX_EN is undefined.
REQ-025 beat_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 Simultaneous S2 drain and S1 refill in the same cycle SHALL lose no beat and duplicate no beat.
REQ-027 out_data and out_id SHALL remain stable while out_valid is high and out_ready is low.

Reset
REQ-028 While rst is high, the following SHALL be forced: S1 and S2 valid flags to 0; out_valid, req_ready, busy to 0; rr_ptr to 0; beat_cnt to 0; out_data and out_id to 0.
REQ-029 A reset asserted mid-stream SHALL discard in-flight beats and SHALL NOT emit them after release.
REQ-030 The first grant after reset release SHALL be decided by the first valid requester at or after index 0.

Configuration
REQ-031 Macro SM_CONV_NEGZERO_FIX_EN: when defined, a lane equal to 0x100 SHALL be output as 0x000; all other lanes are unchanged.
REQ-032 Without SM_CONV_NEGZERO_FIX_EN, the behaviour SHALL be exactly that of REQ-022 and REQ-024.

Structure
REQ-033 Shared package sm_conv_pkg SHALL hold the SM_W=9 constant, a lane typedef, and a function that computes the id width.
REQ-034 One sub-module, sm_lane_conv, SHALL perform the combinational single-lane conversion; it is instantiated LANES times between S1 and S2.

Verification
REQ-035 Single requester 0 sends lane0=0x1FF with out_ready=1. Required: out_valid two cycles later, lane0=0x101, out_id=0, beat_cnt=1.
REQ-036 All 4 requesters hold req_valid continuously with out_ready=1. Required: grants 0,1,2,3,0,1...; one beat per cycle.
REQ-037 out_ready=0 for 5 cycles with a beat in S2. Required: out_data and out_id held; S1 holds one beat; req_ready=0; no beat lost after release.
REQ-038 Lane=0x100 is sent. Required: output 0x100 without the macro; output 0x000 with SM_CONV_NEGZERO_FIX_EN.
REQ-039 rst is pulsed while both stages are full. Required: out_valid=0 next cycle; rr_ptr=0; no stale beat after release.
REQ-040 beat_cnt is preloaded via force to 0xFFFFFFFF and one beat is delivered. Required: beat_cnt=0.
